db_fe_setting_arbiter: RTL and testbench

//  Shares the single settings/readback bus of one daughterboard frontend core between NUM_REQ requesters
//  (e.g. host command path, timed command queue, calibration sequencer). Round-robin grants one transaction at a time,

---
 rtl/db_fe_setting_arbiter_if.sv | 32 +++
 rtl/db_fe_setting_arbiter.sv | 140 ++++++++++++++
 tb/tb_db_fe_setting_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/db_fe_setting_arbiter_if.sv
// Settings/readback bus bundle between NUM_REQ requesters, the arbiter and one frontend core.
// Per-requester fields are packed [NUM_REQ-1:0][W-1:0], so requester i sits at bits [W*i+W-1:W*i].
interface db_fe_setting_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_rb;
  logic [NUM_REQ-1:0][7:0]   req_addr;
  logic [NUM_REQ-1:0][31:0]  req_data;
  logic [NUM_REQ-1:0][7:0]   req_rb_addr;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [63:0]               rsp_data;
  logic                      rsp_timeout;
  logic                      set_stb;
  logic [7:0]                set_addr;
  logic [31:0]               set_data;
  logic [7:0]                rb_addr;
  logic                      rb_stb;
  logic [63:0]               rb_data;
  logic                      busy;

  modport slave (
    input  req_valid, req_rb, req_addr, req_data, req_rb_addr, rb_stb, rb_data,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, set_stb, set_addr, set_data, rb_addr, busy
  );

  modport master (
    output req_valid, req_rb, req_addr, req_data, req_rb_addr, rb_stb, rb_data,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, set_stb, set_addr, set_data, rb_addr, busy
  );
endinterface

// File: rtl/db_fe_setting_arbiter.sv
// Round-robin arbiter sharing one frontend settings/readback bus; one transaction in flight,
// readbacks wait for rb_stb up to RB_TIMEOUT cycles before completing with a timeout flag.
module db_fe_setting_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int RB_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  db_fe_setting_arbiter_if.slave  bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(RB_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SET, RB_WAIT, DONE} state_t;

  typedef struct packed {
    logic        rb;
    logic [7:0]  addr;
    logic [31:0] data;
  } req_t;

  state_t          state_q, state_d;
  req_t            req_q, req_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      rb_addr_q, rb_addr_d;
  logic [63:0]     rsp_data_q, rsp_data_d;
  logic            rsp_to_q, rsp_to_d;
  logic [PW-1:0]   gnt_idx, idx_w;
  logic            found, gnt_vld, rb_last;
  int              idx;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx_w   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(ptr_q) + i) % NUM_REQ;
      idx_w = PW'(idx);
      if (!found && bus.req_valid[idx_w]) begin
        found   = 1'b1;
        gnt_idx = idx_w;
      end
    end
  end

  // Gated by reset so nothing is accepted while the block is held in reset.
  assign gnt_vld = found && (state_q == IDLE) && !reset;
  assign rb_last = (cnt_q == CW'(RB_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = SET;
      SET:     if (req_q.rb && bus.rb_stb) state_d = DONE;
               else if (req_q.rb)          state_d = RB_WAIT;
               else                        state_d = DONE;
      RB_WAIT: if (bus.rb_stb || rb_last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.set_stb   = (state_q == SET);
    bus.busy      = (state_q != IDLE);
    if (gnt_vld)           bus.req_ready[gnt_idx] = 1'b1;
    if (state_q == DONE)   bus.rsp_valid[ptr_q]   = 1'b1;
    // New readback address is presented in the accept cycle itself.
    bus.rb_addr = (gnt_vld && bus.req_rb[gnt_idx]) ? bus.req_rb_addr[gnt_idx] : rb_addr_q;
  end

  assign bus.set_addr    = req_q.addr;
  assign bus.set_data    = req_q.data;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_to_q;

  always_comb begin
    req_d      = req_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    rb_addr_d  = rb_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_to_d   = rsp_to_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        req_d.rb   = bus.req_rb[gnt_idx];
        req_d.addr = bus.req_addr[gnt_idx];
        req_d.data = bus.req_data[gnt_idx];
        ptr_d      = gnt_idx;
        if (bus.req_rb[gnt_idx]) rb_addr_d = bus.req_rb_addr[gnt_idx];
      end
      SET: begin
        if (!req_q.rb || bus.rb_stb) begin
          rsp_data_d = req_q.rb ? bus.rb_data : 64'd0;
          rsp_to_d   = 1'b0;
        end
      end
      RB_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.rb_stb) begin
          rsp_data_d = bus.rb_data;
          rsp_to_d   = 1'b0;
        end else if (rb_last) begin
          rsp_data_d = 64'd0;
          rsp_to_d   = 1'b1;
        end
      end
      DONE:    cnt_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= '0;
      ptr_q      <= PW'(NUM_REQ - 1);
      cnt_q      <= '0;
      rb_addr_q  <= '0;
      rsp_data_q <= '0;
      rsp_to_q   <= 1'b0;
    end else begin
      req_q      <= req_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rb_addr_q  <= rb_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_to_q   <= rsp_to_d;
    end
  end
endmodule

// File: tb/tb_db_fe_setting_arbiter.sv
// Directed bench for db_fe_setting_arbiter: three requesters, readback timeout of 8 cycles.
module tb_db_fe_setting_arbiter;
  localparam int NR = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  db_fe_setting_arbiter_if #(.NUM_REQ(NR)) bus ();

  db_fe_setting_arbiter #(.NUM_REQ(NR), .RB_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic drive_idle();
    bus.req_valid   = '0;
    bus.req_rb      = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.req_rb_addr = '0;
    bus.rb_stb      = 1'b0;
    bus.rb_data     = '0;
  endtask

  task automatic set_req(input int i, input logic rb, input logic [7:0] a,
                         input logic [31:0] d, input logic [7:0] ra);
    bus.req_rb[i]      = rb;
    bus.req_addr[i]    = a;
    bus.req_data[i]    = d;
    bus.req_rb_addr[i] = ra;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_rb = 3'b111;
    bus.req_rb_addr = {8'h55, 8'h55, 8'h55};
    bus.rb_stb = 1'b1;
    #2;
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.set_stb, bus.busy, bus.rsp_timeout} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b/%b/%b/%b/%b exp=0", bus.req_ready, bus.rsp_valid,
               bus.set_stb, bus.busy, bus.rsp_timeout);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.set_addr, bus.set_data, bus.rb_addr, bus.rsp_data} !== '0) begin
      bad++;
      $display("FAIL reset_data got addr=%h data=%h rb_addr=%h rsp=%h exp=0", bus.set_addr,
               bus.set_data, bus.rb_addr, bus.rsp_data);
    end
    total++;
    if ({bus.req_ready, bus.busy} !== '0) begin
      bad++;
      $display("FAIL reset_held got ready=%b busy=%b exp=0", bus.req_ready, bus.busy);
    end
    next_cycle();
    drive_idle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [2:0] g[4];
    int gc[4], sc[4];
    int n = 0, m = 0;
    set_req(0, 1'b0, 8'h01, 32'h100, 8'h00);
    set_req(1, 1'b0, 8'h02, 32'h200, 8'h00);
    for (int i = 0; i < 13; i++) begin
      if (i > 0) next_cycle();
      bus.req_valid = (n < 4) ? 3'b011 : 3'b000;
      @(negedge clk);
      if (bus.req_ready != 0 && n < 4) begin g[n] = bus.req_ready; gc[n] = cyc; n++; end
      if (bus.set_stb && m < 4) begin sc[m] = cyc; m++; end
    end
    total++;
    if (n != 4 || m != 4) begin
      bad++;
      $display("FAIL rr_count got grants=%0d stbs=%0d exp=4/4", n, m);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (g[k] !== ((k % 2 == 0) ? 3'b001 : 3'b010)) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b exp=%b", k, g[k], (k % 2 == 0) ? 3'b001 : 3'b010);
      end
    end
    for (int k = 1; k < 4; k++) begin
      total++;
      if (gc[k] - gc[k-1] != 3 || sc[k] - sc[k-1] != 3) begin
        bad++;
        $display("FAIL rr_spacing%0d got grant=%0d stb=%0d exp=3", k, gc[k] - gc[k-1], sc[k] - sc[k-1]);
      end
    end
    total++;
    if (sc[0] != gc[0] + 1) begin
      bad++;
      $display("FAIL rr_stb_latency got=%0d exp=1", sc[0] - gc[0]);
    end
    next_cycle();
  endtask

  task automatic test_single_write();
    set_req(0, 1'b0, 8'hA0, 32'h1234, 8'h00);
    bus.req_valid = 3'b001;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 3'b001 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL wr_accept got ready=%b busy=%b exp=001/0", bus.req_ready, bus.busy);
    end
    next_cycle();
    bus.req_valid = '0;
    @(negedge clk);
    total++;
    if (bus.set_stb !== 1'b1 || bus.set_addr !== 8'hA0 || bus.set_data !== 32'h1234) begin
      bad++;
      $display("FAIL wr_set got stb=%b addr=%h data=%h exp=1/a0/00001234", bus.set_stb,
               bus.set_addr, bus.set_data);
    end
    total++;
    if (bus.rsp_valid !== 3'b000 || bus.req_ready !== 3'b000) begin
      bad++;
      $display("FAIL wr_set_quiet got rsp=%b ready=%b exp=0", bus.rsp_valid, bus.req_ready);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 3'b001 || bus.rsp_data !== 64'd0 || bus.set_stb !== 1'b0) begin
      bad++;
      $display("FAIL wr_rsp got rsp=%b data=%h stb=%b exp=001/0/0", bus.rsp_valid, bus.rsp_data,
               bus.set_stb);
    end
    total++;
    if (bus.set_addr !== 8'hA0) begin
      bad++;
      $display("FAIL wr_addr_hold got=%h exp=a0", bus.set_addr);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 3'b000) begin
      bad++;
      $display("FAIL wr_idle got busy=%b rsp=%b exp=0/000", bus.busy, bus.rsp_valid);
    end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [2:0] g[2];
    logic [7:0] sa[2];
    logic [2:0] pend = 3'b101;
    int n = 0, m = 0;
    set_req(0, 1'b0, 8'h0A, 32'hA, 8'h00);
    set_req(2, 1'b0, 8'h2C, 32'hC, 8'h00);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) next_cycle();
      bus.req_valid = pend;
      @(negedge clk);
      if (bus.req_ready != 0 && n < 2) begin g[n] = bus.req_ready; pend &= ~bus.req_ready; n++; end
      if (bus.set_stb && m < 2) begin sa[m] = bus.set_addr; m++; end
    end
    total++;
    if (g[0] !== 3'b100 || g[1] !== 3'b001) begin
      bad++;
      $display("FAIL wrap_order got=%b,%b exp=100,001", g[0], g[1]);
    end
    total++;
    if (sa[0] !== 8'h2C || sa[1] !== 8'h0A) begin
      bad++;
      $display("FAIL wrap_addr got=%h,%h exp=2c,0a", sa[0], sa[1]);
    end
    bus.req_valid = '0;
    next_cycle();
  endtask

  task automatic test_readback();
    int nrsp = 0, rcyc = -1;
    logic [2:0] rv = '0;
    logic [63:0] rd = '0;
    logic rt = 1'bx;
    set_req(1, 1'b1, 8'h30, 32'h5, 8'h10);
    bus.req_valid = 3'b010;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 3'b010 || bus.rb_addr !== 8'h10) begin
      bad++;
      $display("FAIL rb_accept got ready=%b rb_addr=%h exp=010/10", bus.req_ready, bus.rb_addr);
    end
    for (int i = 1; i < 10; i++) begin
      next_cycle();
      bus.req_valid = '0;
      bus.rb_stb  = (i == 5);
      bus.rb_data = (i == 5) ? 64'hDEADBEEF_00C0FFEE : 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      if (i == 1) begin
        total++;
        if (bus.set_stb !== 1'b1 || bus.rb_addr !== 8'h10) begin
          bad++;
          $display("FAIL rb_set got stb=%b rb_addr=%h exp=1/10", bus.set_stb, bus.rb_addr);
        end
      end
      if (bus.rsp_valid != 0) begin
        nrsp++; rcyc = i; rv = bus.rsp_valid; rd = bus.rsp_data; rt = bus.rsp_timeout;
      end
    end
    bus.rb_stb = 1'b0;
    total++;
    if (nrsp != 1 || rcyc != 6) begin
      bad++;
      $display("FAIL rb_latency got count=%0d cycle=%0d exp=1/6", nrsp, rcyc);
    end
    total++;
    if (rv !== 3'b010 || rd !== 64'hDEADBEEF_00C0FFEE || rt !== 1'b0) begin
      bad++;
      $display("FAIL rb_rsp got v=%b data=%h to=%b exp=010/deadbeef00c0ffee/0", rv, rd, rt);
    end
    total++;
    if (bus.rsp_data !== 64'hDEADBEEF_00C0FFEE || bus.rb_addr !== 8'h10) begin
      bad++;
      $display("FAIL rb_hold got data=%h rb_addr=%h exp=deadbeef00c0ffee/10", bus.rsp_data, bus.rb_addr);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    int nrsp = 0, rcyc = -1;
    logic [63:0] rd = 64'hx;
    logic rt = 1'bx;
    set_req(0, 1'b1, 8'h40, 32'h7, 8'h44);
    bus.req_valid = 3'b001;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 3'b001 || bus.rb_addr !== 8'h44) begin
      bad++;
      $display("FAIL to_accept got ready=%b rb_addr=%h exp=001/44", bus.req_ready, bus.rb_addr);
    end
    for (int i = 1; i < 15; i++) begin
      next_cycle();
      bus.req_valid = '0;
      @(negedge clk);
      if (bus.rsp_valid != 0) begin nrsp++; rcyc = i; rd = bus.rsp_data; rt = bus.rsp_timeout; end
    end
    total++;
    if (nrsp != 1 || rcyc - 1 < TO || rcyc - 1 > TO + 1) begin
      bad++;
      $display("FAIL to_once got count=%0d after_stb=%0d exp=1/%0d..%0d", nrsp, rcyc - 1, TO, TO + 1);
    end
    total++;
    if (rt !== 1'b1 || rd !== 64'd0) begin
      bad++;
      $display("FAIL to_rsp got to=%b data=%h exp=1/0", rt, rd);
    end
    next_cycle();
    bus.rb_stb = 1'b1;
    bus.rb_data = 64'h77;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 3'b000 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL to_stray got rsp=%b busy=%b exp=000/0", bus.rsp_valid, bus.busy);
    end
    next_cycle();
    bus.rb_stb = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rsp_data !== 64'd0 || bus.rsp_timeout !== 1'b1 || bus.rsp_valid !== 3'b000) begin
      bad++;
      $display("FAIL to_stray_hold got data=%h to=%b rsp=%b exp=0/1/000", bus.rsp_data,
               bus.rsp_timeout, bus.rsp_valid);
    end
    next_cycle();
  endtask

  task automatic test_rb_in_set();
    set_req(2, 1'b1, 8'h2A, 32'h9, 8'h2B);
    bus.req_valid = 3'b100;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 3'b100) begin
      bad++;
      $display("FAIL set_rb_accept got=%b exp=100", bus.req_ready);
    end
    next_cycle();
    bus.req_valid = '0;
    bus.rb_stb = 1'b1;
    bus.rb_data = 64'h01234567_89ABCDEF;
    next_cycle();
    bus.rb_stb = 1'b0;
    bus.rb_data = '0;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 3'b100 || bus.rsp_data !== 64'h01234567_89ABCDEF || bus.rsp_timeout !== 1'b0) begin
      bad++;
      $display("FAIL set_rb_rsp got v=%b data=%h to=%b exp=100/0123456789abcdef/0", bus.rsp_valid,
               bus.rsp_data, bus.rsp_timeout);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int nrsp = 0;
    set_req(0, 1'b1, 8'h5A, 32'h5, 8'h66);
    bus.req_valid = 3'b001;
    next_cycle();
    bus.req_valid = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy got=%b exp=1", bus.busy);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.set_stb, bus.rsp_valid, bus.rsp_timeout, bus.req_ready} !== '0) begin
      bad++;
      $display("FAIL mid_async_ctrl got busy=%b stb=%b rsp=%b to=%b ready=%b exp=0", bus.busy,
               bus.set_stb, bus.rsp_valid, bus.rsp_timeout, bus.req_ready);
    end
    total++;
    if ({bus.rsp_data, bus.set_addr, bus.set_data, bus.rb_addr} !== '0) begin
      bad++;
      $display("FAIL mid_async_data got rsp=%h addr=%h data=%h rb_addr=%h exp=0", bus.rsp_data,
               bus.set_addr, bus.set_data, bus.rb_addr);
    end
    next_cycle();
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 0 || bus.set_stb) nrsp++;
      next_cycle();
    end
    total++;
    if (nrsp != 0) begin
      bad++;
      $display("FAIL mid_no_rsp got=%0d exp=0", nrsp);
    end
    set_req(0, 1'b0, 8'h01, 32'h1, 8'h00);
    set_req(1, 1'b0, 8'h02, 32'h2, 8'h00);
    bus.req_valid = 3'b011;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 3'b001) begin
      bad++;
      $display("FAIL mid_first_grant got=%b exp=001", bus.req_ready);
    end
    next_cycle();
    bus.req_valid = '0;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_wrap();
    test_readback();
    test_timeout();
    test_rb_in_set();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
